// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: sequences 1/2-byte CPU memory requests as acknowledged byte accesses
module cpu_mem_responder #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_page_wrap,
  output logic        req_ready,
  output logic [15:0] MDR,
  output logic        done,
  output logic        err,
  output logic [15:0] bus_addr,
  output logic        bus_re,
  output logic        bus_we,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, mdr_q, mdr_d, baddr_q, baddr_d;
  logic        wrap_q, wrap_d, err_q, err_d, re_q, re_d, we_q, we_d;
  logic [7:0]  wait_q, wait_d, bwd_q, bwd_d;
  logic        hit, is_rd, two;
  logic [7:0]  rd;
  logic [15:0] addr2;
  assign hit   = bus_ack || (wait_q == 8'(TIMEOUT - 1));
  assign rd    = bus_ack ? bus_rdata : 8'hFF;
  assign addr2 = wrap_q ? {addr_q[15:8], addr_q[7:0] + 8'd1} : addr_q + 16'd1;
  assign is_rd = (op_q == 3'd1) || (op_q == 3'd2);
  assign two   = (op_q == 3'd2) || (op_q == 3'd4);
  assign req_ready = state_q == IDLE;
  assign done      = state_q == RESP;
  assign err       = done && err_q;
  assign MDR       = mdr_q;
  assign bus_addr  = baddr_q;
  assign bus_re    = re_q;
  assign bus_we    = we_q;
  assign bus_wdata = bwd_q;
  // next-state: accept, per-byte access with timeout-as-open-bus, response pulse
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    mdr_d   = mdr_q;
    wait_d  = wait_q;
    baddr_d = baddr_q;
    bwd_d   = bwd_q;
    re_d    = re_q;
    we_d    = we_q;
    case (state_q)
      IDLE: if (req_valid && req_op != 3'd0 && req_op < 3'd5) begin
        state_d = ACC_LO;
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wrap_d  = req_page_wrap;
        err_d   = 1'b0;
        wait_d  = 8'd0;
        baddr_d = req_addr;
        bwd_d   = req_wdata[7:0];
        re_d    = req_op < 3'd3;
        we_d    = req_op >= 3'd3;
      end
      ACC_LO: if (hit) begin
        err_d  = err_q | ~bus_ack;
        wait_d = 8'd0;
        mdr_d  = !is_rd ? mdr_q : two ? {mdr_q[15:8], rd} : {8'h00, rd};
        if (two) begin
          state_d = ACC_HI;
          baddr_d = addr2;
          bwd_d   = wdata_q[15:8];
        end else begin
          state_d = RESP;
          re_d    = 1'b0;
          we_d    = 1'b0;
        end
      end else wait_d = wait_q + 8'd1;
      ACC_HI: if (hit) begin
        err_d   = err_q | ~bus_ack;
        wait_d  = 8'd0;
        mdr_d   = is_rd ? {rd, mdr_q[7:0]} : mdr_q;
        state_d = RESP;
        re_d    = 1'b0;
        we_d    = 1'b0;
      end else wait_d = wait_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      mdr_q   <= 16'd0;
      wait_q  <= 8'd0;
      baddr_q <= 16'd0;
      bwd_q   <= 8'd0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      mdr_q   <= mdr_d;
      wait_q  <= wait_d;
      baddr_q <= baddr_d;
      bwd_q   <= bwd_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end
endmodule
